// File: rtl/mem_stage_ctrl_pkg.sv
// Shared memory-stage definitions: operation codes, FSM encodings and
// small decode helpers used by the controller and its lane aligner.
package mem_stage_ctrl_pkg;

  localparam int WORD_W   = 32;
  localparam int MEM_OP_W = 4;

  // Memory operation codes carried in the EX/MEM register
  localparam logic [MEM_OP_W-1:0] MEM_OP_NOP      = 4'd0;
  localparam logic [MEM_OP_W-1:0] MEM_OP_RD_BYTE  = 4'd1;
  localparam logic [MEM_OP_W-1:0] MEM_OP_RD_HALF  = 4'd2;
  localparam logic [MEM_OP_W-1:0] MEM_OP_RD_WORD  = 4'd3;
  localparam logic [MEM_OP_W-1:0] MEM_OP_RD_UBYTE = 4'd4;
  localparam logic [MEM_OP_W-1:0] MEM_OP_RD_UHALF = 4'd5;
  localparam logic [MEM_OP_W-1:0] MEM_OP_WR_BYTE  = 4'd6;
  localparam logic [MEM_OP_W-1:0] MEM_OP_WR_HALF  = 4'd7;
  localparam logic [MEM_OP_W-1:0] MEM_OP_WR_WORD  = 4'd8;

  localparam int MEMC_ST_W = 2;

  typedef enum logic [MEMC_ST_W-1:0] {
    MEMC_ST_IDLE = 2'd0,
    MEMC_ST_WAIT = 2'd1,
    MEMC_ST_DONE = 2'd2
  } memc_state_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_NONE = 2'd3
  } mem_size_e;

  // True for any load code
  function automatic logic mem_op_is_rd(input logic [MEM_OP_W-1:0] op);
    logic r;
    case (op)
      MEM_OP_RD_BYTE, MEM_OP_RD_HALF, MEM_OP_RD_WORD,
      MEM_OP_RD_UBYTE, MEM_OP_RD_UHALF: r = 1'b1;
      default:                          r = 1'b0;
    endcase
    return r;
  endfunction

  // True for any store code
  function automatic logic mem_op_is_wr(input logic [MEM_OP_W-1:0] op);
    logic r;
    case (op)
      MEM_OP_WR_BYTE, MEM_OP_WR_HALF, MEM_OP_WR_WORD: r = 1'b1;
      default:                                        r = 1'b0;
    endcase
    return r;
  endfunction

  // Access size; unknown codes and NOP report SIZE_NONE
  function automatic mem_size_e mem_op_size(input logic [MEM_OP_W-1:0] op);
    mem_size_e r;
    case (op)
      MEM_OP_RD_BYTE, MEM_OP_RD_UBYTE, MEM_OP_WR_BYTE: r = SIZE_BYTE;
      MEM_OP_RD_HALF, MEM_OP_RD_UHALF, MEM_OP_WR_HALF: r = SIZE_HALF;
      MEM_OP_RD_WORD, MEM_OP_WR_WORD:                  r = SIZE_WORD;
      default:                                         r = SIZE_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, store-data replication,
// load-lane selection with sign/zero extension, and alignment check.
module mem_lane_align
  import mem_stage_ctrl_pkg::*;
(
  input  logic [MEM_OP_W-1:0] mem_op,
  input  logic [1:0]          offset,
  input  logic [WORD_W-1:0]   wr_data,
  input  logic [WORD_W-1:0]   rdata,
  output logic [3:0]          be,
  output logic [WORD_W-1:0]   wdata,
  output logic [WORD_W-1:0]   ld_data,
  output logic                aligned
);

  logic [WORD_W-1:0] shifted_s;
  logic [7:0]        byte_s;
  logic [15:0]       half_s;

  // Bring the addressed lane down to bit 0 for extension
  always_comb begin
    shifted_s = rdata >> {offset, 3'b000};
    byte_s    = shifted_s[7:0];
    half_s    = shifted_s[15:0];
  end

  // Size-dependent enables, write replication and alignment
  always_comb begin
    be      = 4'b0000;
    wdata   = wr_data;
    aligned = 1'b1;
    case (mem_op_size(mem_op))
      SIZE_BYTE: begin
        be      = 4'b0001 << offset;
        wdata   = {4{wr_data[7:0]}};
        aligned = 1'b1;
      end
      SIZE_HALF: begin
        be      = 4'b0011 << {offset[1], 1'b0};
        wdata   = {2{wr_data[15:0]}};
        aligned = (offset[0] == 1'b0);
      end
      SIZE_WORD: begin
        be      = 4'b1111;
        wdata   = wr_data;
        aligned = (offset == 2'b00);
      end
      default: begin
        be      = 4'b0000;
        wdata   = wr_data;
        aligned = 1'b1;
      end
    endcase
  end

  // Load-result extension by load kind
  always_comb begin
    ld_data = 32'h0000_0000;
    case (mem_op)
      MEM_OP_RD_BYTE:  ld_data = {{24{byte_s[7]}}, byte_s};
      MEM_OP_RD_UBYTE: ld_data = {24'h00_0000, byte_s};
      MEM_OP_RD_HALF:  ld_data = {{16{half_s[15]}}, half_s};
      MEM_OP_RD_UHALF: ld_data = {16'h0000, half_s};
      MEM_OP_RD_WORD:  ld_data = rdata;
      default:         ld_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: sequences one load/store at a time onto a
// single-port data memory via req/ack, stalls the pipeline while the
// access is outstanding, and reports misalignment and ack timeouts.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT  = 16,
  parameter int TO_CNT_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                op_valid,
  input  logic [MEM_OP_W-1:0] mem_op,
  input  logic [WORD_W-1:0]   addr,
  input  logic [WORD_W-1:0]   wr_data,
  output logic                stall,
  output logic [WORD_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                err_misaligned,
  output logic                err_timeout,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [WORD_W-1:0]   dmem_addr,
  output logic [3:0]          dmem_be,
  output logic [WORD_W-1:0]   dmem_wdata,
  input  logic                dmem_ack,
  input  logic [WORD_W-1:0]   dmem_rdata
);

  localparam logic                TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

  memc_state_e         state_r;
  logic [TO_CNT_W-1:0] to_cnt_r;
  logic [MEM_OP_W-1:0] op_r;
  logic [1:0]          off_r;

  logic                accept_s;
  logic [MEM_OP_W-1:0] op_sel_s;
  logic [1:0]          off_sel_s;
  logic [3:0]          be_s;
  logic [WORD_W-1:0]   wdata_s;
  logic [WORD_W-1:0]   ld_data_s;
  logic                aligned_s;

  // Accept decode and lane-aligner input select: live op in IDLE, latched op otherwise
  always_comb begin
    accept_s = op_valid && (mem_op_is_rd(mem_op) || mem_op_is_wr(mem_op));
    if (state_r == MEMC_ST_IDLE) begin
      op_sel_s  = mem_op;
      off_sel_s = addr[1:0];
    end else begin
      op_sel_s  = op_r;
      off_sel_s = off_r;
    end
  end

  mem_lane_align u_lane_align (
    .mem_op  (op_sel_s),
    .offset  (off_sel_s),
    .wr_data (wr_data),
    .rdata   (dmem_rdata),
    .be      (be_s),
    .wdata   (wdata_s),
    .ld_data (ld_data_s),
    .aligned (aligned_s)
  );

  // Pipeline hold: on the accept cycle and throughout WAIT, including the ack cycle
  always_comb begin
    stall = 1'b0;
    case (state_r)
      MEMC_ST_IDLE: stall = accept_s;
      MEMC_ST_WAIT: stall = 1'b1;
      default:      stall = 1'b0;
    endcase
  end

  // Controller FSM, timeout counter and registered memory/pipeline outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= MEMC_ST_IDLE;
      to_cnt_r       <= '0;
      op_r           <= MEM_OP_NOP;
      off_r          <= 2'b00;
      rd_data        <= 32'h0000_0000;
      rd_valid       <= 1'b0;
      err_misaligned <= 1'b0;
      err_timeout    <= 1'b0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= 32'h0000_0000;
      dmem_be        <= 4'b0000;
      dmem_wdata     <= 32'h0000_0000;
    end else begin
      case (state_r)
        MEMC_ST_IDLE: begin
          rd_valid       <= 1'b0;
          err_misaligned <= 1'b0;
          err_timeout    <= 1'b0;
          to_cnt_r       <= '0;
          if (accept_s && aligned_s) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_op_is_wr(mem_op);
            dmem_addr  <= {addr[WORD_W-1:2], 2'b00};
            dmem_be    <= be_s;
            dmem_wdata <= wdata_s;
            op_r       <= mem_op;
            off_r      <= addr[1:0];
            state_r    <= MEMC_ST_WAIT;
          end else if (accept_s) begin
            // Misaligned: never touch memory, just report
            err_misaligned <= 1'b1;
            state_r        <= MEMC_ST_DONE;
          end else begin
            state_r <= MEMC_ST_IDLE;
          end
        end
        MEMC_ST_WAIT: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            to_cnt_r <= '0;
            if (mem_op_is_rd(op_r)) begin
              rd_data  <= ld_data_s;
              rd_valid <= 1'b1;
            end else begin
              rd_valid <= 1'b0;
            end
            state_r <= MEMC_ST_DONE;
          end else if (TO_EN && (to_cnt_r == TO_LAST)) begin
            dmem_req    <= 1'b0;
            err_timeout <= 1'b1;
            rd_data     <= 32'h0000_0000;
            to_cnt_r    <= '0;
            state_r     <= MEMC_ST_DONE;
          end else begin
            to_cnt_r <= to_cnt_r + {{(TO_CNT_W-1){1'b0}}, 1'b1};
            state_r  <= MEMC_ST_WAIT;
          end
        end
        MEMC_ST_DONE: begin
          // EX/MEM still shows the finished op here, so inputs are ignored
          rd_valid       <= 1'b0;
          err_misaligned <= 1'b0;
          err_timeout    <= 1'b0;
          dmem_req       <= 1'b0;
          to_cnt_r       <= '0;
          state_r        <= MEMC_ST_IDLE;
        end
        default: begin
          dmem_req <= 1'b0;
          to_cnt_r <= '0;
          state_r  <= MEMC_ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl (TIMEOUT=4).
module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                op_valid;
  logic [MEM_OP_W-1:0] mem_op;
  logic [31:0]         addr;
  logic [31:0]         wr_data;
  logic                stall;
  logic [31:0]         rd_data;
  logic                rd_valid;
  logic                err_misaligned;
  logic                err_timeout;
  logic                dmem_req;
  logic                dmem_we;
  logic [31:0]         dmem_addr;
  logic [3:0]          dmem_be;
  logic [31:0]         dmem_wdata;
  logic                dmem_ack;
  logic [31:0]         dmem_rdata;

  int checks = 0;
  int errors = 0;

  mem_stage_ctrl #(.TIMEOUT(4), .TO_CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .mem_op(mem_op),
    .addr(addr), .wr_data(wr_data), .stall(stall), .rd_data(rd_data),
    .rd_valid(rd_valid), .err_misaligned(err_misaligned), .err_timeout(err_timeout),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op_valid = 1'b0; mem_op = MEM_OP_NOP; addr = 32'h0;
    wr_data = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({stall, rd_valid, err_misaligned, err_timeout, dmem_req, dmem_we, dmem_be} !== 10'b0 ||
        rd_data !== 32'h0 || dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b be=%b rd=%h addr=%h wd=%h, expected all zero",
               dmem_req, dmem_be, rd_data, dmem_addr, dmem_wdata);
    end
    // Start a load, let it sit in WAIT, then reset mid-access
    op_valid = 1'b1; mem_op = MEM_OP_RD_WORD; addr = 32'h0000_0100;
    tick();
    op_valid = 1'b0; mem_op = MEM_OP_NOP;
    #1;
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++; $display("FAIL reset_pre_req: got %b expected 1", dmem_req);
    end
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (dmem_req !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL reset_mid_wait: got req=%b stall=%b expected 0 0", dmem_req, stall);
    end
    tick();
    rst_n = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_ack = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || rd_valid !== 1'b0 || stall !== 1'b0 || rd_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_late_ack: got req=%b rv=%b stall=%b rd=%h expected 0 0 0 0",
               dmem_req, rd_valid, stall, rd_data);
    end
  endtask

  task automatic do_load_byte(input logic [MEM_OP_W-1:0] op, input logic [31:0] exp_data,
                              input string name);
    int stall_cycles;
    stall_cycles = 0;
    op_valid = 1'b1; mem_op = op; addr = 32'h0000_1003; dmem_rdata = 32'h80FF_FFFF;
    #1;
    if (stall === 1'b1) stall_cycles++;
    tick();
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h0000_1000 || dmem_be !== 4'b1000) begin
      errors++;
      $display("FAIL %s_req: got req=%b we=%b addr=%h be=%b expected 1 0 00001000 1000",
               name, dmem_req, dmem_we, dmem_addr, dmem_be);
    end
    dmem_ack = 1'b1;
    #1;
    if (stall === 1'b1) stall_cycles++;
    tick();
    dmem_ack = 1'b0;
    #1;
    if (stall === 1'b1) stall_cycles++;
    checks++;
    if (rd_data !== exp_data || rd_valid !== 1'b1 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: got rd=%h rv=%b req=%b expected %h 1 0",
               name, rd_data, rd_valid, dmem_req, exp_data);
    end
    checks++;
    if (stall_cycles !== 2) begin
      errors++; $display("FAIL %s_stall: got %0d cycles expected 2", name, stall_cycles);
    end
    op_valid = 1'b0; mem_op = MEM_OP_NOP;
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++; $display("FAIL %s_rv_pulse: got %b expected 0", name, rd_valid);
    end
  endtask

  task automatic test_load_byte();
    do_load_byte(MEM_OP_RD_BYTE, 32'hFFFF_FF80, "lb");
    do_load_byte(MEM_OP_RD_UBYTE, 32'h0000_0080, "lbu");
  endtask

  task automatic test_store_half();
    int stall_cycles;
    int bad_hold;
    stall_cycles = 0; bad_hold = 0;
    op_valid = 1'b1; mem_op = MEM_OP_WR_HALF; addr = 32'h0000_2002; wr_data = 32'h1234_ABCD;
    #1;
    if (stall === 1'b1) stall_cycles++;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== 4'b1100 ||
          dmem_wdata !== 32'hABCD_ABCD || dmem_addr !== 32'h0000_2000) bad_hold++;
      if (i == 2) dmem_ack = 1'b1;
      #1;
      if (stall === 1'b1) stall_cycles++;
      tick();
    end
    dmem_ack = 1'b0;
    #1;
    if (stall === 1'b1) stall_cycles++;
    checks++;
    if (bad_hold !== 0) begin
      errors++;
      $display("FAIL sh_wait_hold: got %0d bad cycles (last we=%b be=%b wd=%h) expected 0",
               bad_hold, dmem_we, dmem_be, dmem_wdata);
    end
    checks++;
    if (stall_cycles !== 4) begin
      errors++; $display("FAIL sh_stall: got %0d cycles expected 4", stall_cycles);
    end
    checks++;
    if (rd_valid !== 1'b0 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL sh_done: got rv=%b req=%b expected 0 0", rd_valid, dmem_req);
    end
    op_valid = 1'b0; mem_op = MEM_OP_NOP;
    tick();
  endtask

  task automatic test_misaligned();
    op_valid = 1'b1; mem_op = MEM_OP_RD_WORD; addr = 32'h0000_2001;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL mis_stall: got %b expected 1", stall);
    end
    tick();
    checks++;
    if (err_misaligned !== 1'b1 || dmem_req !== 1'b0 || rd_valid !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL mis_done: got err=%b req=%b rv=%b stall=%b expected 1 0 0 0",
               err_misaligned, dmem_req, rd_valid, stall);
    end
    op_valid = 1'b0; mem_op = MEM_OP_NOP;
    tick();
    checks++;
    if (err_misaligned !== 1'b0) begin
      errors++; $display("FAIL mis_pulse: got %b expected 0", err_misaligned);
    end
  endtask

  task automatic test_timeout();
    int req_cycles;
    req_cycles = 0;
    op_valid = 1'b1; mem_op = MEM_OP_RD_WORD; addr = 32'h0000_0100; dmem_ack = 1'b0;
    tick();
    while (dmem_req === 1'b1 && req_cycles < 10) begin
      req_cycles++;
      tick();
    end
    checks++;
    if (req_cycles !== 4) begin
      errors++; $display("FAIL to_req_cycles: got %0d expected 4", req_cycles);
    end
    checks++;
    if (err_timeout !== 1'b1 || rd_data !== 32'h0 || stall !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL to_done: got err=%b rd=%h stall=%b rv=%b expected 1 00000000 0 0",
               err_timeout, rd_data, stall, rd_valid);
    end
    op_valid = 1'b0; mem_op = MEM_OP_NOP;
    tick();
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++; $display("FAIL to_pulse: got %b expected 0", err_timeout);
    end
  endtask

  task automatic test_back_to_back();
    op_valid = 1'b1; mem_op = MEM_OP_WR_WORD; addr = 32'h0000_0004; wr_data = 32'h1122_3344;
    tick();
    checks++;
    if (dmem_we !== 1'b1 || dmem_be !== 4'b1111 || dmem_wdata !== 32'h1122_3344) begin
      errors++;
      $display("FAIL b2b_sw: got we=%b be=%b wd=%h expected 1 1111 11223344",
               dmem_we, dmem_be, dmem_wdata);
    end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    // In DONE: next op is presented but must not be taken yet
    mem_op = MEM_OP_RD_UHALF; addr = 32'h0000_0006; dmem_rdata = 32'hBEEF_0000;
    #1;
    checks++;
    if (stall !== 1'b0 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL b2b_done_ignore: got stall=%b req=%b expected 0 0", stall, dmem_req);
    end
    tick();
    checks++;
    if (stall !== 1'b1 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: got stall=%b req=%b expected 1 0", stall, dmem_req);
    end
    tick();
    checks++;
    if (dmem_req !== 1'b1 || dmem_addr !== 32'h0000_0004 || dmem_be !== 4'b1100 || dmem_we !== 1'b0) begin
      errors++;
      $display("FAIL b2b_lhu_req: got req=%b addr=%h be=%b we=%b expected 1 00000004 1100 0",
               dmem_req, dmem_addr, dmem_be, dmem_we);
    end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    checks++;
    if (rd_data !== 32'h0000_BEEF || rd_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_lhu_data: got rd=%h rv=%b expected 0000beef 1", rd_data, rd_valid);
    end
    mem_op = MEM_OP_NOP;
    tick();
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL nop_stall: got %b expected 0", stall);
    end
    tick();
    checks++;
    if (dmem_req !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL nop_req: got req=%b stall=%b expected 0 0", dmem_req, stall);
    end
    op_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
